// File: rtl/mips_trace_buffer.sv
// Commit-trace recorder: timestamps register writebacks and stores from the MIPS
// pipeline and queues them in a first-word-fall-through FIFO for a host reader.
module mips_trace_buffer #(
    parameter int DEPTH    = 16,
    parameter int TS_WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     en,
    input  logic                     clear,
    input  logic                     reg_we,
    input  logic [4:0]               reg_write_addr,
    input  logic [31:0]              reg_write_data,
    input  logic                     mem_we,
    input  logic [31:0]              mem_addr,
    input  logic [31:0]              mem_write_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     out_type,
    output logic [31:0]              out_addr,
    output logic [31:0]              out_data,
    output logic [TS_WIDTH-1:0]      out_ts,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic [7:0]               drop_count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    // Record storage, written without reset; only pointer/count state is reset.
    logic                st_type [DEPTH];
    logic [31:0]         st_addr [DEPTH];
    logic [31:0]         st_data [DEPTH];
    logic [TS_WIDTH-1:0] st_ts   [DEPTH];

    logic [PW-1:0]       rd_ptr_reg;
    logic [PW-1:0]       wr_ptr_reg;
    logic [CW-1:0]       count_reg;
    logic [TS_WIDTH-1:0] ts_reg;
    logic                overflow_reg;
    logic [7:0]          drop_count_reg;

    // Last popped record, shown while the FIFO is empty.
    logic                last_type_reg;
    logic [31:0]         last_addr_reg;
    logic [31:0]         last_data_reg;
    logic [TS_WIDTH-1:0] last_ts_reg;

    logic                reg_event;
    logic                mem_event;
    logic [1:0]          n_events;
    logic [CW-1:0]       free_slots;
    logic                accept;
    logic                drop;
    logic                pop;
    logic [CW-1:0]       count_next;
    logic [PW-1:0]       mem_slot;
    logic [8:0]          drop_sum;
    logic [7:0]          drop_count_next;
    logic [DEPTH-1:0]    wr_reg_slot;
    logic [DEPTH-1:0]    wr_mem_slot;

    logic                head_type;
    logic [31:0]         head_addr;
    logic [31:0]         head_data;
    logic [TS_WIDTH-1:0] head_ts;

    assign reg_event  = en & reg_we & (reg_write_addr != 5'd0);
    assign mem_event  = en & mem_we;
    assign n_events   = {1'b0, reg_event} + {1'b0, mem_event};
    assign free_slots = CW'(DEPTH) - count_reg;

    // Space is judged on start-of-cycle occupancy; a pair is accepted or dropped whole.
    assign accept = !clear && (n_events != 2'd0) && (CW'(n_events) <= free_slots);
    assign drop   = !clear && (n_events != 2'd0) && (CW'(n_events) >  free_slots);

    assign out_valid  = (count_reg != '0);
    assign pop        = out_valid & out_ready & !clear;
    assign count_next = count_reg + (accept ? CW'(n_events) : CW'(0)) - CW'(pop);

    // The older writeback record takes the first slot when both events fire.
    assign mem_slot = reg_event ? wr_ptr_reg + PW'(1) : wr_ptr_reg;

    assign drop_sum        = {1'b0, drop_count_reg} + 9'(n_events);
    assign drop_count_next = drop_sum[8] ? 8'hFF : drop_sum[7:0];

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot_we
            assign wr_reg_slot[gi] = accept && reg_event && (wr_ptr_reg == PW'(gi));
            assign wr_mem_slot[gi] = accept && mem_event && (mem_slot == PW'(gi));
        end
    endgenerate

    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (wr_reg_slot[i]) begin
                st_type[i] <= 1'b0;
                st_addr[i] <= {27'd0, reg_write_addr};
                st_data[i] <= reg_write_data;
                st_ts[i]   <= ts_reg;
            end else if (wr_mem_slot[i]) begin
                st_type[i] <= 1'b1;
                st_addr[i] <= mem_addr;
                st_data[i] <= mem_write_data;
                st_ts[i]   <= ts_reg;
            end
        end
    end

    assign head_type = st_type[rd_ptr_reg];
    assign head_addr = st_addr[rd_ptr_reg];
    assign head_data = st_data[rd_ptr_reg];
    assign head_ts   = st_ts[rd_ptr_reg];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_reg     <= '0;
            wr_ptr_reg     <= '0;
            count_reg      <= '0;
            ts_reg         <= '0;
            overflow_reg   <= 1'b0;
            drop_count_reg <= 8'd0;
            last_type_reg  <= 1'b0;
            last_addr_reg  <= 32'd0;
            last_data_reg  <= 32'd0;
            last_ts_reg    <= '0;
        end else if (clear) begin
            rd_ptr_reg     <= '0;
            wr_ptr_reg     <= '0;
            count_reg      <= '0;
            ts_reg         <= '0;
            overflow_reg   <= 1'b0;
            drop_count_reg <= 8'd0;
            last_type_reg  <= 1'b0;
            last_addr_reg  <= 32'd0;
            last_data_reg  <= 32'd0;
            last_ts_reg    <= '0;
        end else begin
            if (en) begin
                ts_reg <= ts_reg + TS_WIDTH'(1);
            end
            if (accept) begin
                wr_ptr_reg <= wr_ptr_reg + PW'(n_events);
            end
            if (pop) begin
                rd_ptr_reg    <= rd_ptr_reg + PW'(1);
                last_type_reg <= head_type;
                last_addr_reg <= head_addr;
                last_data_reg <= head_data;
                last_ts_reg   <= head_ts;
            end
            if (drop) begin
                overflow_reg   <= 1'b1;
                drop_count_reg <= drop_count_next;
            end
            count_reg <= count_next;
        end
    end

    assign out_type   = out_valid ? head_type : last_type_reg;
    assign out_addr   = out_valid ? head_addr : last_addr_reg;
    assign out_data   = out_valid ? head_data : last_data_reg;
    assign out_ts     = out_valid ? head_ts   : last_ts_reg;
    assign count      = count_reg;
    assign overflow   = overflow_reg;
    assign drop_count = drop_count_reg;

endmodule

// File: tb/tb_mips_trace_buffer.sv
// Directed bench for mips_trace_buffer (DEPTH = 16, TS_WIDTH = 16).
module tb_mips_trace_buffer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic        clear;
    logic        reg_we;
    logic [4:0]  reg_write_addr;
    logic [31:0] reg_write_data;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_write_data;
    logic        out_valid;
    logic        out_ready;
    logic        out_type;
    logic [31:0] out_addr;
    logic [31:0] out_data;
    logic [15:0] out_ts;
    logic [4:0]  count;
    logic        overflow;
    logic [7:0]  drop_count;

    int checks = 0;
    int errors = 0;

    mips_trace_buffer #(.DEPTH(16), .TS_WIDTH(16)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .clear(clear),
        .reg_we(reg_we), .reg_write_addr(reg_write_addr), .reg_write_data(reg_write_data),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_write_data(mem_write_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_type(out_type),
        .out_addr(out_addr), .out_data(out_data), .out_ts(out_ts),
        .count(count), .overflow(overflow), .drop_count(drop_count)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        reg_we = 1'b0; reg_write_addr = 5'd0; reg_write_data = 32'd0;
        mem_we = 1'b0; mem_addr = 32'd0; mem_write_data = 32'd0;
        out_ready = 1'b0; clear = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; en = 1'b0; idle_inputs();
        step(); step();
        rst_n = 1'b1;
        step();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b want 0", out_valid); end
        checks++; if (count !== 5'd0) begin errors++; $display("FAIL reset_count got %0d want 0", count); end
        checks++; if (overflow !== 1'b0 || drop_count !== 8'd0) begin errors++; $display("FAIL reset_flags got ovf=%0b drops=%0d want 0/0", overflow, drop_count); end
        checks++; if (out_addr !== 32'd0 || out_data !== 32'd0 || out_ts !== 16'd0 || out_type !== 1'b0) begin errors++; $display("FAIL reset_fields got type=%0b addr=%h data=%h ts=%0d want zeros", out_type, out_addr, out_data, out_ts); end
        $display("reset: valid=%0b count=%0d", out_valid, count);
    endtask

    // ts is 0 here; three idle enabled cycles bring it to 3.
    task automatic test_reg_write();
        en = 1'b1;
        step(); step(); step();
        reg_we = 1'b1; reg_write_addr = 5'd5; reg_write_data = 32'h2A;
        step();
        reg_we = 1'b0;
        checks++; if (out_valid !== 1'b1 || count !== 5'd1) begin errors++; $display("FAIL regw_valid got valid=%0b count=%0d want 1/1", out_valid, count); end
        checks++; if (out_type !== 1'b0 || out_addr !== 32'd5 || out_data !== 32'h2A || out_ts !== 16'd3) begin errors++; $display("FAIL regw_rec got t=%0b a=%h d=%h ts=%0d want 0/5/2a/3", out_type, out_addr, out_data, out_ts); end
        $display("regw: type=%0b addr=%h data=%h ts=%0d", out_type, out_addr, out_data, out_ts);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        checks++; if (out_valid !== 1'b0 || count !== 5'd0) begin errors++; $display("FAIL regw_drain got valid=%0b count=%0d want 0/0", out_valid, count); end
        checks++; if (out_addr !== 32'd5 || out_data !== 32'h2A || out_ts !== 16'd3) begin errors++; $display("FAIL regw_hold got a=%h d=%h ts=%0d want 5/2a/3", out_addr, out_data, out_ts); end
        $display("drain: valid=%0b held addr=%h", out_valid, out_addr);
    endtask

    // ts enters at 5.
    task automatic test_filter_gating();
        reg_we = 1'b1; reg_write_addr = 5'd0; reg_write_data = 32'hDEAD;
        step();
        reg_we = 1'b0;
        checks++; if (count !== 5'd0) begin errors++; $display("FAIL zero_filter got count=%0d want 0", count); end
        en = 1'b0; mem_we = 1'b1; mem_addr = 32'h40; mem_write_data = 32'h77;
        step(); step();
        checks++; if (count !== 5'd0 || out_valid !== 1'b0) begin errors++; $display("FAIL en_gate got count=%0d want 0", count); end
        en = 1'b1;
        step();
        mem_we = 1'b0;
        checks++; if (count !== 5'd1 || out_type !== 1'b1 || out_addr !== 32'h40 || out_ts !== 16'd6) begin errors++; $display("FAIL ts_hold got count=%0d t=%0b a=%h ts=%0d want 1/1/40/6", count, out_type, out_addr, out_ts); end
        $display("gating: count=%0d ts=%0d", count, out_ts);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    // ts enters at 8.
    task automatic test_simultaneous();
        reg_we = 1'b1; reg_write_addr = 5'd8; reg_write_data = 32'h11;
        mem_we = 1'b1; mem_addr = 32'h100; mem_write_data = 32'h22;
        step();
        reg_we = 1'b0; mem_we = 1'b0;
        checks++; if (count !== 5'd2) begin errors++; $display("FAIL pair_count got %0d want 2", count); end
        checks++; if (out_type !== 1'b0 || out_addr !== 32'd8 || out_data !== 32'h11 || out_ts !== 16'd8) begin errors++; $display("FAIL pair_first got t=%0b a=%h d=%h ts=%0d want 0/8/11/8", out_type, out_addr, out_data, out_ts); end
        $display("pair head: type=%0b addr=%h ts=%0d", out_type, out_addr, out_ts);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        checks++; if (count !== 5'd1 || out_type !== 1'b1 || out_addr !== 32'h100 || out_data !== 32'h22 || out_ts !== 16'd8) begin errors++; $display("FAIL pair_second got c=%0d t=%0b a=%h d=%h ts=%0d want 1/1/100/22/8", count, out_type, out_addr, out_data, out_ts); end
        $display("pair next: type=%0b addr=%h ts=%0d", out_type, out_addr, out_ts);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        checks++; if (count !== 5'd0) begin errors++; $display("FAIL pair_drain got %0d want 0", count); end
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 15; i++) begin
            reg_we = 1'b1; reg_write_addr = 5'(i + 1); reg_write_data = 32'(i + 100);
            step();
        end
        reg_we = 1'b0;
        checks++; if (count !== 5'd15) begin errors++; $display("FAIL fill_15 got %0d want 15", count); end
        reg_we = 1'b1; reg_write_addr = 5'd20; mem_we = 1'b1; mem_addr = 32'h200;
        step();
        mem_we = 1'b0;
        checks++; if (count !== 5'd15 || overflow !== 1'b1 || drop_count !== 8'd2) begin errors++; $display("FAIL pair_drop got c=%0d ovf=%0b drops=%0d want 15/1/2", count, overflow, drop_count); end
        reg_write_addr = 5'd16; reg_write_data = 32'd115;
        step();
        reg_we = 1'b0;
        checks++; if (count !== 5'd16 || drop_count !== 8'd2) begin errors++; $display("FAIL single_fits got c=%0d drops=%0d want 16/2", count, drop_count); end
        checks++; if (out_addr !== 32'd1 || out_data !== 32'd100) begin errors++; $display("FAIL full_head got a=%h d=%h want 1/64", out_addr, out_data); end
        $display("overflow: count=%0d ovf=%0b drops=%0d", count, overflow, drop_count);
    endtask

    task automatic test_saturation();
        mem_we = 1'b1; mem_addr = 32'h300;
        for (int i = 0; i < 300; i++) step();
        mem_we = 1'b0;
        checks++; if (drop_count !== 8'd255 || count !== 5'd16) begin errors++; $display("FAIL drop_sat got drops=%0d c=%0d want 255/16", drop_count, count); end
        reg_we = 1'b1; reg_write_addr = 5'd30; out_ready = 1'b1;
        step();
        reg_we = 1'b0; out_ready = 1'b0;
        checks++; if (count !== 5'd15 || drop_count !== 8'd255) begin errors++; $display("FAIL full_pop got c=%0d drops=%0d want 15/255", count, drop_count); end
        checks++; if (out_addr !== 32'd2 || out_data !== 32'd101) begin errors++; $display("FAIL full_pop_head got a=%h d=%h want 2/65", out_addr, out_data); end
        $display("saturate: count=%0d drops=%0d", count, drop_count);
    endtask

    task automatic test_clear_and_reset();
        clear = 1'b1; reg_we = 1'b1; reg_write_addr = 5'd9; out_ready = 1'b1;
        step();
        clear = 1'b0; out_ready = 1'b0;
        checks++; if (count !== 5'd0 || out_valid !== 1'b0 || overflow !== 1'b0 || drop_count !== 8'd0) begin errors++; $display("FAIL clear got c=%0d v=%0b ovf=%0b drops=%0d want 0/0/0/0", count, out_valid, overflow, drop_count); end
        reg_write_data = 32'h55;
        step();
        reg_we = 1'b0;
        checks++; if (count !== 5'd1 || out_addr !== 32'd9 || out_ts !== 16'd0) begin errors++; $display("FAIL clear_ts got c=%0d a=%h ts=%0d want 1/9/0", count, out_addr, out_ts); end
        $display("clear: count=%0d ts=%0d", count, out_ts);
        mem_we = 1'b1; mem_addr = 32'h400;
        step(); step();
        mem_we = 1'b0; out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        checks++; if (count !== 5'd2 || out_valid !== 1'b1) begin errors++; $display("FAIL pre_reset got c=%0d v=%0b want 2/1", count, out_valid); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0 || count !== 5'd0 || out_addr !== 32'd0) begin errors++; $display("FAIL async_reset got v=%0b c=%0d a=%h want 0/0/0", out_valid, count, out_addr); end
        $display("async reset: valid=%0b count=%0d", out_valid, count);
        #1 rst_n = 1'b1;
        step();
        checks++; if (count !== 5'd0 || out_valid !== 1'b0) begin errors++; $display("FAIL post_reset got c=%0d v=%0b want 0/0", count, out_valid); end
    endtask

    initial begin
        test_reset();
        test_reg_write();
        test_filter_gating();
        test_simultaneous();
        test_overflow();
        test_saturation();
        test_clear_and_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
